// File: rtl/mux_nx1_pkg.sv
// Shared types and helpers for the registered N-to-1 word selector.
package mux_nx1_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width for n inputs, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    if (n <= 1) return 1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 word selector; an index at or beyond NUM_IN yields zero.
module mux_nx1
  import mux_nx1_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_IN = 8,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*DATA_W-1:0] in_bus,
  input  logic [SEL_W-1:0]         idx,
  output logic [DATA_W-1:0]        dout_c
);

  always_comb begin
    dout_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (idx == SEL_W'(k)) dout_c = in_bus[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/mux_nx1_seq.sv
// Registered N-to-1 selector with MANUAL single-load and SCAN walk modes, valid/ready output.
// Define MUX_NX1_SEQ_SNAPSHOT_EN to capture in_bus on scan start so scans are coherent.
module mux_nx1_seq
  import mux_nx1_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NUM_IN = 8,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_bus,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     load,
  input  logic                     start,
  output logic                     busy,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned    BUS_W    = NUM_IN * DATA_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);
  localparam logic           SINGLE   = (NUM_IN == 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                free_c;
  logic                scan_go_c;
  logic                man_go_c;
  logic [SEL_W-1:0]    mux_idx_c;
  logic [BUS_W-1:0]    mux_src_c;
  logic [DATA_W-1:0]   mux_data_c;

`ifdef MUX_NX1_SEQ_SNAPSHOT_EN
  logic [BUS_W-1:0]    snap_q, snap_d;

  // Scan beats after the first come from the captured bank.
  always_comb begin
    mux_src_c = (state_q == SCAN) ? snap_q : in_bus;
    snap_d    = scan_go_c ? in_bus : snap_q;
  end
`else
  always_comb begin
    mux_src_c = in_bus;
  end
`endif

  always_comb begin
    free_c    = !out_valid_q || out_ready;
    scan_go_c = (state_q == IDLE) && free_c && start && (mode == MODE_SCAN);
    man_go_c  = (state_q == IDLE) && free_c && load && (mode == MODE_MANUAL);
    if (state_q == SCAN)        mux_idx_c = cnt_q;
    else if (mode == MODE_SCAN) mux_idx_c = '0;
    else                        mux_idx_c = sel;
  end

  mux_nx1 #(
    .DATA_W (DATA_W),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_bus (mux_src_c),
    .idx    (mux_idx_c),
    .dout_c (mux_data_c)
  );

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      IDLE: begin
        if (scan_go_c) begin
          out_data_d  = mux_data_c;
          out_idx_d   = '0;
          out_last_d  = SINGLE;
          out_valid_d = 1'b1;
          state_d     = SINGLE ? IDLE : SCAN;
          cnt_d       = SINGLE ? '0 : SEL_W'(1);
        end else if (man_go_c) begin
          out_data_d  = mux_data_c;
          out_idx_d   = sel;
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (free_c) begin
          out_data_d  = mux_data_c;
          out_idx_d   = cnt_q;
          out_last_d  = (cnt_q == LAST_IDX);
          out_valid_d = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MUX_NX1_SEQ_SNAPSHOT_EN
      snap_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MUX_NX1_SEQ_SNAPSHOT_EN
      snap_q      <= snap_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nx1_seq.sv
// Bench for mux_nx1_seq: an expected-beat queue for the 8-input instance, directed checks on a 5-input one.
module tb_mux_nx1_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-input instance
  logic [95:0] in8;
  logic        mode8, load8, start8, ready8;
  logic [2:0]  sel8;
  logic        busy8, last8, valid8;
  logic [11:0] data8;
  logic [2:0]  idx8;

  // 5-input instance
  logic [59:0] in5;
  logic        mode5, load5, start5, ready5;
  logic [2:0]  sel5;
  logic        busy5, last5, valid5;
  logic [11:0] data5;
  logic [2:0]  idx5;

  mux_nx1_seq #(.DATA_W(12), .NUM_IN(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_bus(in8), .mode(mode8), .sel(sel8), .load(load8),
    .start(start8), .busy(busy8), .out_data(data8), .out_idx(idx8),
    .out_last(last8), .out_valid(valid8), .out_ready(ready8)
  );

  mux_nx1_seq #(.DATA_W(12), .NUM_IN(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_bus(in5), .mode(mode5), .sel(sel5), .load(load5),
    .start(start5), .busy(busy5), .out_data(data5), .out_idx(idx5),
    .out_last(last5), .out_valid(valid5), .out_ready(ready5)
  );

  typedef struct {
    logic [11:0] d;
    logic [2:0]  i;
    logic        l;
  } beat_t;

  beat_t exp_q8[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_acc8   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words8(input logic [11:0] base);
    for (int k = 0; k < 8; k++) in8[k*12 +: 12] = base + 12'(k);
  endtask

  // A scan yields every word in index order, last flagged on the final one.
  task automatic push_scan(input logic [95:0] bus);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.d = bus[k*12 +: 12];
      b.i = 3'(k);
      b.l = (k == 7);
      exp_q8.push_back(b);
    end
  endtask

  task automatic push_one(input logic [11:0] d, input logic [2:0] i, input logic l);
    beat_t b;
    b.d = d;
    b.i = i;
    b.l = l;
    exp_q8.push_back(b);
  endtask

  // Accepted beats must match the queue; a stalled beat must not change.
  logic        hold_pend = 1'b0;
  logic [11:0] hold_d;
  logic [2:0]  hold_i;
  logic        hold_l;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(valid8), 32'd1);
        check("hold_data",  32'(data8),  32'(hold_d));
        check("hold_idx",   32'(idx8),   32'(hold_i));
        check("hold_last",  32'(last8),  32'(hold_l));
      end
      if (valid8 && ready8) begin
        n_acc8++;
        if (exp_q8.size() == 0) begin
          check("unexpected_beat_idx", 32'(idx8), 32'hFFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q8.pop_front();
          check("beat_data", 32'(data8), 32'(e.d));
          check("beat_idx",  32'(idx8),  32'(e.i));
          check("beat_last", 32'(last8), 32'(e.l));
        end
      end
      hold_pend = valid8 && !ready8;
      hold_d    = data8;
      hold_i    = idx8;
      hold_l    = last8;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int guard;
    logic [11:0] w;
    in8 = '0; mode8 = 0; load8 = 0; start8 = 0; ready8 = 0; sel8 = '0;
    in5 = '0; mode5 = 0; load5 = 0; start5 = 0; ready5 = 0; sel5 = '0;

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(valid8), 32'd0);
    check("rst_data",  32'(data8),  32'd0);
    check("rst_idx",   32'(idx8),   32'd0);
    check("rst_last",  32'(last8),  32'd0);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_valid5", 32'(valid5), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Full-rate scan, with a start during SCAN that must be ignored
    set_words8(12'h100);
    mode8 = 1; ready8 = 1;
    push_scan(in8);
    start8 = 1; tick(); start8 = 0;
    check("scan_busy", 32'(busy8), 32'd1);
    check("scan_first_valid", 32'(valid8), 32'd1);
    tick(); tick();
    start8 = 1; tick(); start8 = 0;
    repeat (4) tick();
    check("scan_end_idx",  32'(idx8),  32'd7);
    check("scan_end_last", 32'(last8), 32'd1);
    check("scan_end_busy", 32'(busy8), 32'd0);
    tick();
    check("scan_drop_valid", 32'(valid8), 32'd0);
    check("scan_queue", 32'(exp_q8.size()), 32'd0);

    // Backpressure on beat 1 for three cycles
    acc0 = n_acc8;
    set_words8(12'h140);
    push_scan(in8);
    start8 = 1; tick(); start8 = 0;
    tick();
    ready8 = 0;
    repeat (3) tick();
    check("bp_held_idx", 32'(idx8), 32'd1);
    ready8 = 1;
    guard = 0;
    while ((exp_q8.size() != 0 || valid8) && guard < 30) begin
      tick();
      guard++;
    end
    check("bp_timeout", 32'(guard < 30), 32'd1);
    check("bp_accepted", 32'(n_acc8 - acc0), 32'd8);

    // MANUAL sel=5 held under ready=0; start and load while held are ignored
    set_words8(12'h300);
    mode8 = 0; sel8 = 3'd5; ready8 = 0;
    push_one(12'h305, 3'd5, 1'b1);
    load8 = 1; tick(); load8 = 0;
    check("man_data",  32'(data8),  32'h305);
    check("man_idx",   32'(idx8),   32'd5);
    check("man_last",  32'(last8),  32'd1);
    check("man_valid", 32'(valid8), 32'd1);
    mode8 = 1; start8 = 1; tick(); start8 = 0;
    check("man_start_ignored_busy", 32'(busy8), 32'd0);
    mode8 = 0; sel8 = 3'd2; load8 = 1; tick(); load8 = 0;
    repeat (3) tick();
    check("man_still_idx", 32'(idx8), 32'd5);
    ready8 = 1; tick();
    check("man_drop_valid", 32'(valid8), 32'd0);

    // Bus changes after beat 0
    set_words8(12'h100);
    mode8 = 1;
    push_one(12'h100, 3'd0, 1'b0);
    for (int k = 1; k < 8; k++) begin
`ifdef MUX_NX1_SEQ_SNAPSHOT_EN
      w = 12'h100 + 12'(k);
`else
      w = 12'hFFF;
`endif
      push_one(w, 3'(k), k == 7);
    end
    start8 = 1; tick(); start8 = 0;
    in8 = {96{1'b1}};
    repeat (8) tick();
    check("snap_queue", 32'(exp_q8.size()), 32'd0);

    // Reset mid-scan at beat 3
    set_words8(12'h200);
    push_scan(in8);
    start8 = 1; tick(); start8 = 0;
    repeat (3) tick();
    check("pre_rst_idx", 32'(idx8), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(valid8), 32'd0);
    check("midrst_data",  32'(data8),  32'd0);
    check("midrst_idx",   32'(idx8),   32'd0);
    check("midrst_last",  32'(last8),  32'd0);
    check("midrst_busy",  32'(busy8),  32'd0);
    exp_q8.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_rst_valid", 32'(valid8), 32'd0);
    end
    check("post_rst_busy", 32'(busy8), 32'd0);

    // Randomised requests against the expected-beat queue
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 8; k++) in8[k*12 +: 12] = 12'($urandom);
      ready8 = 1;
      mode8  = 1'($urandom);
      if (mode8) begin
        push_scan(in8);
        start8 = 1;
      end else begin
        sel8 = 3'($urandom);
        push_one(in8[sel8*12 +: 12], sel8, 1'b1);
        load8 = 1;
      end
      tick();
      start8 = 0; load8 = 0;
      guard = 0;
      while (busy8 && guard < 60) begin
        ready8 = 1'($urandom);
        tick();
        guard++;
      end
      check("rand_scan_timeout", 32'(guard < 60), 32'd1);
      repeat ($urandom_range(0, 2)) begin
        ready8 = 1'($urandom);
        tick();
      end
    end
    ready8 = 1;
    repeat (3) tick();
    check("rand_drain", 32'(exp_q8.size()), 32'd0);

    // 5-input instance: out-of-range select, ignored start while held, then a scan
    for (int k = 0; k < 5; k++) in5[k*12 +: 12] = 12'h200 + 12'(k);
    mode5 = 0; sel5 = 3'd6; ready5 = 0;
    load5 = 1; tick(); load5 = 0;
    check("oor_data",  32'(data5),  32'd0);
    check("oor_idx",   32'(idx5),   32'd6);
    check("oor_valid", 32'(valid5), 32'd1);
    check("oor_last",  32'(last5),  32'd1);
    mode5 = 1; start5 = 1; tick(); start5 = 0;
    check("n5_held_busy", 32'(busy5), 32'd0);
    check("n5_held_idx",  32'(idx5),  32'd6);
    ready5 = 1; tick();
    check("n5_drop_valid", 32'(valid5), 32'd0);
    mode5 = 0; sel5 = 3'd3; load5 = 1; tick(); load5 = 0;
    check("n5_man_data", 32'(data5), 32'h203);
    check("n5_man_idx",  32'(idx5),  32'd3);
    tick();
    mode5 = 1; start5 = 1; tick(); start5 = 0;
    for (int k = 0; k < 5; k++) begin
      check("n5_scan_data", 32'(data5), 32'h200 + 32'(k));
      check("n5_scan_idx",  32'(idx5),  32'(k));
      check("n5_scan_last", 32'(last5), 32'(k == 4));
      if (k < 4) tick();
    end
    check("n5_scan_busy", 32'(busy5), 32'd0);
    tick();
    check("n5_final_valid", 32'(valid5), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_nx1_seq.md
Name: mux_nx1_seq

Overview:
Parametrised, registered N-to-1 word selector with a valid/ready output stage. It succeeds the fixed 8-input, 12-bit combinational mux.
Two modes:
- MANUAL: a `load` pulse registers one selected input.
- SCAN: a `start` pulse makes the block step through all NUM_IN inputs in order, one word per accepted beat, tagged with index and last.
It sits between the FIR tap delay line and a shared, time-multiplexed MAC.

Parameters:
DATA_W, 12, width of each input word and of out_data
NUM_IN, 8, number of inputs; legal range 1..256; need not be a power of 2
SEL_W, $clog2(NUM_IN) (min 1), width of sel and out_idx; local, derived

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_bus  input  NUM_IN*DATA_W  packed inputs; word k = in_bus[k*DATA_W +: DATA_W]
mode  input  1  0 = MANUAL, 1 = SCAN; sampled only in IDLE
sel  input  SEL_W  input index for a MANUAL load
load  input  1  MANUAL load request (single-cycle pulse)
start  input  1  SCAN start request (single-cycle pulse)
busy  output  1  high while state is SCAN
out_data  output  DATA_W  registered selected word
out_idx  output  SEL_W  index of the word in out_data
out_last  output  1  final beat of a scan; always 1 for MANUAL beats
out_valid  output  1  out_data / out_idx / out_last are valid
out_ready  input  1  downstream accepts the beat when out_valid && out_ready

Behaviour:
- Reset (async assert, removed synchronously to clk):
  - out_data=0, out_idx=0, out_last=0, out_valid=0, busy=0
  - state=IDLE, scan counter=0
- free = !out_valid || out_ready. The output register loads only when free. This gives full throughput with out_ready held high.
- Hold rule: while out_valid && !out_ready, out_data / out_idx / out_last are held stable.
- States: IDLE, SCAN.
- IDLE, start=1, mode=1, free:
  - load word 0, set out_idx=0, out_valid=1.
  - out_last = (NUM_IN==1).
  - go to SCAN with counter=1; if NUM_IN==1, stay IDLE.
- IDLE, start=1, mode=1, not free: start is ignored. Requesters wait for out_valid==0 first.
- IDLE, load=1, mode=0, free: load word sel, set out_idx=sel, out_last=1, out_valid=1.
- IDLE, start and load in the same cycle: mode selects which request is honoured; the other is ignored.
- SCAN, each cycle that free is true:
  - load word counter, set out_idx=counter.
  - out_last = (counter==NUM_IN-1).
  - if counter==NUM_IN-1, return to IDLE; otherwise increment counter.
- SCAN, not free: counter holds (backpressure stall).
- A final beat not yet accepted does not block return to IDLE; the hold rule still applies.
- busy is high in SCAN only.
- start and load received in SCAN are ignored.
- Latency: request at edge n → out_valid at edge n+1. A scan with out_ready tied high takes exactly NUM_IN cycles.
- Out-of-range select (sel ≥ NUM_IN, non-power-of-2 NUM_IN): out_data=0, out_idx=sel, out_valid=1.
- out_valid drops after acceptance if nothing new is loaded.
- Reset asserted mid-scan aborts immediately to reset values. No partial beat is emitted after release.
- Without the optional feature, in_bus is read live at each load. Upstream must hold in_bus stable while busy.

Optional Feature:
MUX_NX1_SEQ_SNAPSHOT_EN
- Defined:
  - On the accepted start, all of in_bus is captured into an internal NUM_IN*DATA_W register bank.
  - Scan beats read from this bank, so a scan is coherent even if in_bus changes mid-scan.
  - MANUAL loads still read in_bus live.
- Undefined: no snapshot bank; scan beats read in_bus live.

Decomposition:
- Package mux_nx1_pkg:
  - state enum typedef (IDLE, SCAN)
  - mode constants MODE_MANUAL=1'b0, MODE_SCAN=1'b1
  - function returning SEL_W for NUM_IN (min 1)
- Sub-module mux_nx1: purely combinational parametrised selector (DATA_W, NUM_IN). Returns 0 for an out-of-range index. Instantiated once; its index comes from sel or the counter.

Test Plan:
1. Reset: assert rst mid-scan at beat 3 of 8 → all outputs 0 and busy=0 the same cycle, with no clock edge needed; after release, no output beat appears.
2. SCAN, NUM_IN=8, DATA_W=12, word k=12'h100+k, out_ready=1, start pulse → 8 consecutive beats 12'h100..12'h107, out_idx 0..7, out_last only on idx 7; busy low after the last load.
3. Backpressure: same scan with out_ready low on cycles 2–4 → beat at idx 1 held stable for 3 cycles; no beats lost or duplicated; total 8 accepted.
4. MANUAL, sel=5, load pulse → next cycle out_data=in word 5, out_idx=5, out_last=1; with out_ready=0 the beat holds indefinitely.
5. NUM_IN=5, SEL_W=3, MANUAL sel=6 → out_data=0, out_idx=6, out_valid=1. Also start during SCAN and start while out_valid && !out_ready in IDLE → both ignored.
6. With MUX_NX1_SEQ_SNAPSHOT_EN, change in_bus to all 12'hFFF after beat 0 → beats 1..7 still return the original 12'h101..12'h107. Without the macro, the same stimulus returns 12'hFFF for beats 1..7.
